// File: rtl/ms_mul_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ms_mul_job_scheduler
// Purpose  : Shares one serial stochastic-computing multiplier between
//            NUM_REQ job sources. Round-robin arbitration picks one operand
//            set per job. The multiplier is cleared and then enabled until
//            its done flag or a watchdog limit. The accumulator result is
//            returned with the requester ID over a valid/ready response.
// Ports    : clk, rst (sync, active-low)
//            req_valid/req_ready/req_data  - per-requester job channel
//            rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_timeout - response
//            mul_clr/mul_en/mul_operands    - multiplier control (sole driver)
//            mul_done/mul_result            - multiplier status
//            busy                           - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ms_mul_job_scheduler #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = DATA_WIDTH * NUM_INPUTS,
    parameter int NUM_REQ    = 4,
    parameter int IDW        = $clog2(NUM_REQ),
    parameter int MAX_CYCLES = 300
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [IDW-1:0]                         rsp_id,
    output logic [WXIP1-1:0]                       rsp_data,
    output logic                                   rsp_timeout,
    output logic                                   mul_clr,
    output logic                                   mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]       mul_operands,
    input  logic                                   mul_done,
    input  logic [WXIP1-1:0]                       mul_result,
    output logic                                   busy
);

    localparam int OPW  = NUM_INPUTS * DATA_WIDTH;
    localparam int CNTW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]         state_q,  state_d;
    logic [IDW-1:0]     ptr_q,    ptr_d;
    logic [CNTW-1:0]    cnt_q,    cnt_d;
    logic [NUM_REQ-1:0] ready_q,  ready_d;
    logic [IDW-1:0]     gidx_q,   gidx_d;    // index encoded by ready_q
    logic [IDW-1:0]     id_q,     id_d;
    logic [OPW-1:0]     ops_q,    ops_d;
    logic               tmo_q,    tmo_d;     // how the RUN phase ended
    logic               rv_q,     rv_d;
    logic [WXIP1-1:0]   rdata_q,  rdata_d;
    logic               rto_q,    rto_d;

    logic               grant_hs;
    logic               arb_found;
    logic [IDW-1:0]     arb_idx;
    logic [IDW-1:0]     cand_idx;
    int                 cand;

    // Cyclic priority search starting at the round-robin pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDW'(cand);
            if (!arb_found && req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // ready_q is only ever non-zero while IDLE, so no state qualifier needed.
    assign grant_hs = |(req_valid & ready_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        gidx_d  = gidx_q;
        id_d    = id_q;
        ops_d   = ops_q;
        tmo_d   = tmo_q;
        rv_d    = rv_q;
        rdata_d = rdata_q;
        rto_d   = rto_q;
        case (state_q)
            S_IDLE: begin
                if (grant_hs) begin
                    ops_d   = req_data[gidx_q*OPW +: OPW];
                    id_d    = gidx_q;
                    ptr_d   = (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);
                    ready_d = '0;
                    state_d = S_CLEAR;
                end else begin
                    // Re-arbitrate every cycle so a withdrawn request frees the grant.
                    ready_d = arb_found ? (NUM_REQ'(1) << arb_idx) : '0;
                    gidx_d  = arb_idx;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                // cnt_q==0 is the first RUN cycle: a done left over from the
                // previous job may still be visible, so it is not trusted.
                if (mul_done && (cnt_q != '0)) begin
                    tmo_d   = 1'b0;
                    state_d = S_DRAIN;
                end else if (cnt_q == CNTW'(MAX_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rdata_d = mul_result;
                rto_d   = tmo_q;
                rv_d    = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            gidx_q  <= '0;
            id_q    <= '0;
            ops_q   <= '0;
            tmo_q   <= 1'b0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            rto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            gidx_q  <= gidx_d;
            id_q    <= id_d;
            ops_q   <= ops_d;
            tmo_q   <= tmo_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            rto_q   <= rto_d;
        end
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = rv_q;
    assign rsp_id       = id_q;
    assign rsp_data     = rdata_q;
    assign rsp_timeout  = rto_q;
    assign mul_clr      = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign mul_en       = (state_q == S_RUN);
    assign mul_operands = ops_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
